opb_register_simulink2ppc_snap: RTL
===================================

// Module: opb_register_simulink2ppc_snap
// PURPOSE
//  OPB slave status register carrying data from the fabric (Simulink) side to the PPC.
//  User logic strobes a 32-bit word in; the block holds it for PPC readback.
//  The block also provides fresh/overrun flags and an update counter, so software can
//  detect missed or stale samples. It sits on the OPB bus beside the ppc2simulink
//  control registers and occupies one 256-byte window.
// PARAMETERS
//  C_BASEADDR    32'hFFFFFFFF  window base address (word-aligned, 256 B window)
//  C_HIGHADDR    32'h00000000  window high address (C_BASEADDR+0xFF)
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex5"     target family (informational)
// PORTS
//  OPB_Clk          in   1     bus and user clock; single clock domain
//  OPB_Rst          in   1     asynchronous, active-high reset
//  OPB_ABus         in   [0:31] address, IBM bit order (bit 31 = LSB)
//  OPB_BE           in   [0:3]  byte enables (ignored; full-word access)
//  OPB_DBus         in   [0:31] write data (ignored)
//  OPB_RNW          in   1     1 = read, 0 = write
//  OPB_select       in   1     master transaction valid
//  OPB_seqAddr      in   1     ignored
//  Sl_DBus          out  [0:31] read data; 0 except during the read ack cycle
//  Sl_xferAck       out  1     transfer acknowledge
//  Sl_errAck        out  1     tied 0
//  Sl_retry         out  1     tied 0
//  Sl_toutSup       out  1     tied 0
//  user_data_in     in   [31:0] fabric data word
//  user_data_valid  in   1     1-cycle strobe; captures user_data_in
// BEHAVIOUR
//  Reset: Sl_DBus=0, Sl_xferAck=0; data, flags, count and timestamp all 0.
//  Decode: hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR);
//   word offset = OPB_ABus[24:29].
//  Handshake: xferAck <= hit & ~xferAck. Latency is 1 cycle from hit.
//   - Ack is exactly 1 cycle wide.
//   - A select held through the ack cycle does not re-ack that cycle.
//   - A select still held after the ack cycle starts a new transaction.
//  Sl_DBus is registered on the same edge as xferAck, from pre-edge register values.
//   It is 0 whenever xferAck=0, and for writes.
//  Register map (Sl_DBus[31] = LSB):
//   0x00 DATA   RO: last captured user_data_in.
//   0x04 STATUS RO:
//    - [0] overrun (sticky); Sl_DBus[0] is the MSB.
//    - [1] fresh.
//    - [16:31] update count, 16 bits.
//   0x08 TSTAMP RO: see CONFIGURATION.
//   Other offsets read 0.
//  Writes are acked and ignored.
//  On user_data_valid:
//   - DATA <= user_data_in.
//   - count <= count+1; wraps 0xFFFF -> 0x0000.
//   - fresh <= 1.
//   - overrun <= 1 if fresh was already 1.
//  DATA read ack clears fresh. STATUS read ack clears overrun.
//  Simultaneous events:
//   - valid and DATA read ack on the same cycle: the read returns the old DATA; fresh stays 1.
//   - valid and STATUS read ack on the same cycle: the set wins, so overrun = 1 if fresh was 1.
//  Reset mid-transaction: xferAck drops asynchronously. No ack is issued for the aborted access.
// CONFIGURATION
//  Macro SIM2PPC_TIMESTAMP_EN.
//  Defined:
//   - A free-running 32-bit cycle counter runs from reset (0) and wraps at 2^32.
//   - On user_data_valid, TSTAMP <= counter value at that edge.
//   - Offset 0x08 reads TSTAMP.
//  Undefined: no counter is built, and 0x08 reads 0.
// TESTING
//  - Reset, then read 0x00 and 0x04 -> both return 0.
//    Each ack is 1 cycle wide, 1 cycle after select.
//  - valid with 0xDEADBEEF, then read 0x04 -> 0x40000001; then read 0x00 -> 0xDEADBEEF.
//    Re-read 0x04 -> 0x00000001 (fresh cleared).
//  - Two valids (0x11, 0x22) with no read between, then read 0x04 -> 0xC0000002.
//    Re-read 0x04 -> 0x40000002 (overrun cleared).
//  - valid (0x55) on the same cycle as the DATA read ack, after a prior 0x44 capture
//    -> read returns 0x44; fresh=1.
//  - 65536 valids -> count reads 0x0000; write to 0x00 -> acked, DATA unchanged.
//    Read 0x3C -> 0.
//  - With SIM2PPC_TIMESTAMP_EN: valid at cycle 100 after reset -> 0x08 reads 100.
//    Without the macro: 0x08 reads 0.

Source files
------------

// File: rtl/opb_register_simulink2ppc_snap.sv
// ---------------------------------------------------------------------------------------------
// opb_register_simulink2ppc_snap
//
// OPB slave status register carrying one 32-bit word from the fabric to the PPC. A one-cycle
// user_data_valid strobe captures user_data_in. Fresh/overrun flags and a 16-bit update count
// let software detect missed or stale samples. Occupies one 256-byte window.
//
// Register map (word offsets, Sl_DBus[31] = LSB):
//   0x00 DATA    last captured word; a read ack clears fresh
//   0x04 STATUS  [0] overrun (sticky), [1] fresh, [16:31] update count; read ack clears overrun
//   0x08 TSTAMP  capture timestamp when SIM2PPC_TIMESTAMP_EN is defined, else reads 0
//   others       read 0; all writes are acked and ignored
//
// Ports:
//   OPB_Clk, OPB_Rst        single clock; asynchronous active-high reset
//   OPB_ABus/BE/DBus/RNW    OPB master request (BE, DBus and seqAddr are ignored)
//   OPB_select, OPB_seqAddr
//   Sl_DBus, Sl_xferAck     registered read data and one-cycle acknowledge
//   Sl_errAck/retry/toutSup tied low
//   user_data_in/valid      fabric capture interface
//
// Optional feature macro: SIM2PPC_TIMESTAMP_EN (free-running 32-bit cycle counter + TSTAMP).
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps

module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter logic [55:0] C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid
);

  logic        r_ack;
  logic [0:31] r_dbus;
  logic [31:0] r_data;
  logic        r_fresh;
  logic        r_overrun;
  logic [15:0] r_count;

  logic        w_hit;
  logic        w_issue;
  logic        w_rd_data;
  logic        w_rd_status;
  logic [0:5]  w_offset;
  logic [0:31] w_rd_mux;
  logic [31:0] w_tstamp;
  logic        w_fresh_d;
  logic        w_overrun_d;
  logic        w_unused_ok;

  // Inputs that the register deliberately ignores.
  assign w_unused_ok = ^{OPB_BE, OPB_DBus, OPB_seqAddr, C_FAMILY[0]};

  assign w_hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_offset = OPB_ABus[24:29];

  // A request is accepted only when no ack is already out, so a select held through the ack
  // cycle is not acked twice, but a select held beyond it starts a fresh transaction.
  assign w_issue     = w_hit && !r_ack;
  assign w_rd_data   = w_issue && OPB_RNW && (w_offset == 6'd0);
  assign w_rd_status = w_issue && OPB_RNW && (w_offset == 6'd1);

`ifdef SIM2PPC_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_tstamp;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_cycle  <= 32'd0;
      r_tstamp <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (user_data_valid) begin
        r_tstamp <= r_cycle;
      end
    end
  end

  assign w_tstamp = r_tstamp;
`else
  assign w_tstamp = 32'd0;
`endif

  // Index 0 of the IBM-ordered bus is the MSB, so the concatenation lands overrun on bit 0.
  always_comb begin
    w_rd_mux = '0;
    case (w_offset)
      6'd0:    w_rd_mux = r_data;
      6'd1:    w_rd_mux = {r_overrun, r_fresh, 14'd0, r_count};
      6'd2:    w_rd_mux = w_tstamp;
      default: w_rd_mux = '0;
    endcase
  end

  // Clears act on the edge that issues the ack; a simultaneous capture overrides them, and
  // overrun looks at the pre-edge fresh value.
  always_comb begin
    w_fresh_d   = r_fresh;
    w_overrun_d = r_overrun;
    if (w_rd_data) begin
      w_fresh_d = 1'b0;
    end
    if (w_rd_status) begin
      w_overrun_d = 1'b0;
    end
    if (user_data_valid) begin
      w_fresh_d = 1'b1;
      if (r_fresh) begin
        w_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_ack  <= 1'b0;
      r_dbus <= '0;
    end else begin
      r_ack  <= w_issue;
      r_dbus <= (w_issue && OPB_RNW) ? w_rd_mux : 32'd0;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_data    <= 32'd0;
      r_count   <= 16'd0;
      r_fresh   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_fresh   <= w_fresh_d;
      r_overrun <= w_overrun_d;
      if (user_data_valid) begin
        r_data  <= user_data_in;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
